// File: rtl/wshb_stream_slave.sv
// Wishbone classic slave feeding a first-word-fall-through stream FIFO.
// Define STREAM_RTY_EN to retry full writes and count retries in status.
module wshb_stream_slave #(
  parameter  int DATA_BYTES = 4,
  parameter  int ADR_W      = 32,
  parameter  int DEPTH      = 16,
  localparam int DW         = 8 * DATA_BYTES,
  localparam int PW         = $clog2(DEPTH),
  localparam int LW         = PW + 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [ADR_W-1:0]      adr,
  input  logic [DW-1:0]         dat_ms,
  input  logic [DATA_BYTES-1:0] sel,
  output logic [DW-1:0]         dat_sm,
  output logic                  ack,
  output logic                  err,
  output logic                  rty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADR_W-1:0]      out_adr,
  output logic [DW-1:0]         out_dat,
  output logic [DATA_BYTES-1:0] out_sel,
  output logic [LW-1:0]         level
);

  logic                  r_ack;
  logic                  r_rty;
  logic [DW-1:0]         r_dat_sm;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;
  logic [ADR_W-1:0]      r_mem_adr [DEPTH];
  logic [DW-1:0]         r_mem_dat [DEPTH];
  logic [DATA_BYTES-1:0] r_mem_sel [DEPTH];

  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic        w_valid;
  logic        w_pop;
  logic        w_space;
  logic        w_sel_nz;
  logic        w_push;
  logic        w_ack_nxt;
  logic        w_rty_nxt;
  logic [15:0] w_rty_cnt;
  logic [31:0] w_status;

  // Termination cycles never sample a new request.
  assign w_req    = cyc & stb & ~r_ack & ~r_rty;
  assign w_wr     = w_req & we;
  assign w_rd     = w_req & ~we;
  assign w_valid  = (r_level != '0);
  assign w_pop    = w_valid & out_ready;
  assign w_space  = (r_level < LW'(DEPTH)) | w_pop;
  assign w_sel_nz = |sel;
  assign w_push   = w_wr & w_sel_nz & w_space;

  assign w_ack_nxt = w_rd | (w_wr & (~w_sel_nz | w_space));

`ifdef STREAM_RTY_EN
  logic [15:0] r_rty_cnt;

  assign w_rty_nxt = w_wr & w_sel_nz & ~w_space;
  assign w_rty_cnt = r_rty_cnt;

  // Read samples the old count and clears it on the same edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rty_cnt <= '0;
    end else if (w_rd) begin
      r_rty_cnt <= '0;
    end else if (w_rty_nxt && (r_rty_cnt != 16'hFFFF)) begin
      r_rty_cnt <= r_rty_cnt + 16'd1;
    end
  end
`else
  assign w_rty_nxt = 1'b0;
  assign w_rty_cnt = '0;
`endif

  assign w_status = {w_rty_cnt, 16'(r_level)};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ack    <= 1'b0;
      r_rty    <= 1'b0;
      r_dat_sm <= '0;
    end else begin
      r_ack <= w_ack_nxt;
      r_rty <= w_rty_nxt;
      if (w_rd) begin
        r_dat_sm <= DW'(w_status);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem_adr[r_wptr] <= adr;
      r_mem_dat[r_wptr] <= dat_ms;
      r_mem_sel[r_wptr] <= sel;
    end
  end

  // Head is gated so an empty FIFO shows zeros, not stale storage.
  assign out_valid = w_valid;
  assign out_adr   = w_valid ? r_mem_adr[r_rptr] : '0;
  assign out_dat   = w_valid ? r_mem_dat[r_rptr] : '0;
  assign out_sel   = w_valid ? r_mem_sel[r_rptr] : '0;
  assign level     = r_level;

  assign ack    = r_ack;
  assign rty    = r_rty;
  assign err    = 1'b0;
  assign dat_sm = r_dat_sm;

endmodule

// File: tb/tb_wshb_stream_slave.sv
// Self-checking bench for wshb_stream_slave against a queue-based model.
// Covers the STREAM_RTY_EN retry path when that macro is defined.
module tb_wshb_stream_slave;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_ms = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_adr;
  logic [31:0] out_dat;
  logic [3:0]  out_sel;
  logic [LW-1:0] level;

  wshb_stream_slave #(
    .DATA_BYTES(4),
    .ADR_W(32),
    .DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .cyc(cyc),
    .stb(stb),
    .we(we),
    .adr(adr),
    .dat_ms(dat_ms),
    .sel(sel),
    .dat_sm(dat_sm),
    .ack(ack),
    .err(err),
    .rty(rty),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_adr(out_adr),
    .out_dat(out_dat),
    .out_sel(out_sel),
    .level(level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lvl;
    logic [31:0] stat;
  } vec_t;

  ent_t q[$];
  int   rty_cnt = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  function automatic logic [31:0] model_status();
    return {rty_cnt[15:0], 16'(q.size())};
  endfunction

  // One clock: checks the stream side, then advances the model's pops.
  task automatic step(input logic rdy);
    bit pop;
    out_ready = rdy;
    #1;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("level", 64'(level), 64'(q.size()));
    chk("err", 64'(err), 64'd0);
    pop = rdy && (q.size() != 0);
    if (pop) begin
      chk("head_adr", 64'(out_adr), 64'(q[0].a));
      chk("head_dat", 64'(out_dat), 64'(q[0].d));
      chk("head_sel", 64'(out_sel), 64'(q[0].s));
    end
    @(posedge sys_clk);
    #1;
    if (pop) void'(q.pop_front());
  endtask

  // res: 0 = abandoned, 1 = ack, 2 = rty
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [31:0] pat,
                    input int budget, output int res, output int edges);
    res = 0;
    edges = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = a; dat_ms = d; sel = s;
    for (int k = 0; k < budget && res == 0; k++) begin
      logic r;
      bit sp;
      r = pat[k];
      sp = (q.size() < DEPTH) || (r && q.size() != 0);
      step(r);
      edges = k + 1;
      if (s == 4'd0 || sp) begin
        if (s != 4'd0) q.push_back('{a: a, d: d, s: s});
        res = 1;
      end
`ifdef STREAM_RTY_EN
      else begin
        res = 2;
        if (rty_cnt < 65535) rty_cnt++;
      end
`endif
      chk("wr_ack", 64'(ack), 64'(res == 1));
      chk("wr_rty", 64'(rty), 64'(res == 2));
    end
    cyc = 1'b0; stb = 1'b0;
    step(pat[edges]);
    chk("ack_single", 64'(ack), 64'd0);
    chk("rty_single", 64'(rty), 64'd0);
  endtask

  task automatic rd(input logic rdy, output logic [31:0] st);
    logic [31:0] exp;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    exp = model_status();
    step(rdy);
    chk("rd_ack", 64'(ack), 64'd1);
    chk("rd_dat", 64'(dat_sm), 64'(exp));
    rty_cnt = 0;
    st = dat_sm;
    cyc = 1'b0; stb = 1'b0;
    step(rdy);
    chk("rd_ack_single", 64'(ack), 64'd0);
    chk("rd_dat_hold", 64'(dat_sm), 64'(exp));
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) step(1'b1);
    step(1'b0);
    chk("drained", 64'(level), 64'd0);
  endtask

  task automatic fill();
    int res;
    int e;
    for (int i = 0; i < DEPTH; i++) begin
      wr(32'h100 + 32'(4 * i), 32'(i), 4'hF, 32'd0, 2, res, e);
      chk("fill_ack", 64'(res), 64'd1);
    end
    chk("fill_level", 64'(level), 64'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[8];
    int          res;
    int          e;
    logic [31:0] st;

    tbl[0] = '{w: 1, a: 32'h1000, d: 32'hDEADBEEF, s: 4'hF, lvl: 1, stat: 0};
    tbl[1] = '{w: 1, a: 32'h1004, d: 32'h0BADF00D, s: 4'h0, lvl: 1, stat: 0};
    tbl[2] = '{w: 1, a: 32'h1008, d: 32'h11111111, s: 4'h3, lvl: 2, stat: 0};
    tbl[3] = '{w: 1, a: 32'h100C, d: 32'h22222222, s: 4'hC, lvl: 3, stat: 0};
    tbl[4] = '{w: 1, a: 32'h1010, d: 32'h33333333, s: 4'h1, lvl: 4, stat: 0};
    tbl[5] = '{w: 1, a: 32'h1014, d: 32'h44444444, s: 4'h8, lvl: 5, stat: 0};
    tbl[6] = '{w: 0, a: 32'h0,    d: 32'h0,        s: 4'h0, lvl: 5,
               stat: 32'h00000005};
    tbl[7] = '{w: 1, a: 32'h1018, d: 32'h55555555, s: 4'h0, lvl: 5, stat: 0};

    #2;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rty", 64'(rty), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_dat_sm", 64'(dat_sm), 64'd0);
    chk("rst_out_dat", 64'(out_dat), 64'd0);
    sys_rst = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].w) begin
        wr(tbl[i].a, tbl[i].d, tbl[i].s, 32'd0, 2, res, e);
        chk("tbl_res", 64'(res), 64'd1);
        chk("tbl_edges", 64'(e), 64'd1);
      end else begin
        rd(1'b0, st);
        chk("tbl_stat", 64'(st), 64'(tbl[i].stat));
      end
      chk("tbl_level", 64'(level), 64'(tbl[i].lvl));
      if (i == 0) begin
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_dat", 64'(out_dat), 64'hDEADBEEF);
        chk("single_adr", 64'(out_adr), 64'h1000);
      end
    end
    drain();

    fill();
`ifdef STREAM_RTY_EN
    for (int i = 0; i < 3; i++) begin
      wr(32'h900, 32'hAAAA0000 + 32'(i), 4'hF, 32'd0, 2, res, e);
      chk("retry_res", 64'(res), 64'd2);
      chk("retry_level", 64'(level), 64'(DEPTH));
    end
    rd(1'b0, st);
    chk("retry_cnt3", 64'(st[31:16]), 64'd3);
    rd(1'b0, st);
    chk("retry_cnt0", 64'(st[31:16]), 64'd0);
`else
    wr(32'h200, 32'h16, 4'hF, 32'b100, 6, res, e);
    chk("stall_res", 64'(res), 64'd1);
    chk("stall_edges", 64'(e), 64'd3);
    chk("stall_level", 64'(level), 64'(DEPTH));
    chk("stall_head", 64'(out_dat), 64'd1);
`endif
    drain();

    fill();
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h300; dat_ms = 32'h77; sel = 4'hF;
    step(1'b0);
    #3;
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_ack", 64'(ack), 64'd0);
    chk("mid_rst_rty", 64'(rty), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    sys_rst = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    q.delete();
    rty_cnt = 0;
    wr(32'h10, 32'hCAFE0010, 4'hF, 32'd0, 2, res, e);
    chk("post_rst_res", 64'(res), 64'd1);
    chk("post_rst_edges", 64'(e), 64'd1);
    drain();

    for (int i = 0; i < 100; i++) begin
      wr($urandom, $urandom, 4'($urandom_range(1, 15)), 32'hFFFFFFFF, 2,
         res, e);
      chk("stream_ack", 64'(res), 64'd1);
      chk("stream_level", 64'(level), 64'd0);
    end

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd(1'($urandom), st);
      end else begin
        wr($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
           int'($urandom_range(1, 5)), res, e);
      end
    end
    rd(1'b0, st);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
